// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, rounding/saturation constants and helpers for the stage-3 twiddle multiplier
package fft_pkg;

  localparam int N            = 256;
  localparam int SIZE         = 8;
  localparam int DW           = 16;
  localparam int bit_width_tw = 14;
  localparam int TW_FRAC      = 12;
  localparam int SPAN         = 8;
  localparam int SPAN_LOG2    = $clog2(SPAN);
  localparam int AW           = SIZE - 2;
  localparam int PW           = DW + bit_width_tw;
  localparam int SW           = PW + 1;

  localparam logic signed [DW-1:0] SAT_MAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] ROUND_CONST = SW'(1) << (TW_FRAC - 1);

  // Round half up, then clamp; overflow shows as disagreement among the bits above the DW-1 sign bit
  function automatic logic signed [DW-1:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = (x + ROUND_CONST) >>> TW_FRAC;
    if (t[SW-1:DW-1] == {(SW-DW+1){t[SW-1]}}) begin
      return t[DW-1:0];
    end else if (t[SW-1]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

  // First half of each twiddle group uses W=1; second half walks the ROM from 0
  function automatic logic [AW-1:0] tw_index(input logic [SIZE-1:0] k);
    if (k[SPAN_LOG2-1]) begin
      return AW'(k[SPAN_LOG2-2:0]);
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - registered complex multiply by twiddle with round and saturate, 2-cycle latency
module cmul_round_sat
  import fft_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic                           i_last,
  input  logic signed [DW-1:0]           i_a,
  input  logic signed [DW-1:0]           i_b,
  input  logic signed [bit_width_tw-1:0] i_c,
  input  logic signed [bit_width_tw-1:0] i_s,
  output logic                           o_valid,
  output logic                           o_last,
  output logic signed [DW-1:0]           o_re,
  output logic signed [DW-1:0]           o_im
);

  logic signed [PW-1:0] w_a, w_b, w_c, w_s;
  logic signed [PW-1:0] r_p_ac, r_p_bs, r_p_as, r_p_bc;
  logic                 r_s1_valid, r_s1_last;
  logic signed [SW-1:0] w_re, w_im;
  logic                 r_valid, r_last;
  logic signed [DW-1:0] r_re, r_im;

  assign w_a = {{(PW-DW){i_a[DW-1]}}, i_a};
  assign w_b = {{(PW-DW){i_b[DW-1]}}, i_b};
  assign w_c = {{(PW-bit_width_tw){i_c[bit_width_tw-1]}}, i_c};
  assign w_s = {{(PW-bit_width_tw){i_s[bit_width_tw-1]}}, i_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_p_ac     <= '0;
      r_p_bs     <= '0;
      r_p_as     <= '0;
      r_p_bc     <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_last  <= i_valid & i_last;
      if (i_valid) begin
        r_p_ac <= w_a * w_c;
        r_p_bs <= w_b * w_s;
        r_p_as <= w_a * w_s;
        r_p_bc <= w_b * w_c;
      end
    end
  end

  assign w_re = {r_p_ac[PW-1], r_p_ac} - {r_p_bs[PW-1], r_p_bs};
  assign w_im = {r_p_as[PW-1], r_p_as} + {r_p_bc[PW-1], r_p_bc};

  // Data outputs hold across bubbles so the next butterfly sees stable values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_valid <= r_s1_valid;
      r_last  <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_re <= round_sat(w_re);
        r_im <= round_sat(w_im);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_re    = r_re;
  assign o_im    = r_im;

endmodule

// File: rtl/fft_stage3_twiddle_mult.sv
// rtl/fft_stage3_twiddle_mult.sv - stage-3 sample counter, twiddle ROM addressing and complex multiply
module fft_stage3_twiddle_mult
  import fft_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic signed [DW-1:0]           in_re,
  input  logic signed [DW-1:0]           in_im,
  output logic                           tw_en,
  output logic [SIZE-3:0]                tw_addr,
  input  logic signed [bit_width_tw-1:0] tw_cos,
  input  logic signed [bit_width_tw-1:0] tw_sin,
  output logic                           out_valid,
  output logic signed [DW-1:0]           out_re,
  output logic signed [DW-1:0]           out_im,
  output logic                           out_last
);

  logic [SIZE-1:0]      r_cnt;
  logic [SIZE-1:0]      w_k;
  logic                 w_k_last;
  logic                 r_c0_valid;
  logic                 r_c0_last;
  logic signed [DW-1:0] r_c0_re, r_c0_im;

  // A flagged start-of-frame forces k=0 regardless of where the counter is
  assign w_k      = (in_valid && in_sof) ? '0 : r_cnt;
  assign w_k_last = (w_k == SIZE'(N - 1));

  assign tw_en   = in_valid & ~rst;
  assign tw_addr = rst ? '0 : tw_index(w_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_c0_valid <= 1'b0;
      r_c0_last  <= 1'b0;
      r_c0_re    <= '0;
      r_c0_im    <= '0;
    end else begin
      r_c0_valid <= in_valid;
      r_c0_last  <= in_valid & w_k_last;
      if (in_valid) begin
        r_cnt   <= w_k_last ? '0 : w_k + SIZE'(1);
        r_c0_re <= in_re;
        r_c0_im <= in_im;
      end
    end
  end

  // Data registered here lines up with the ROM word that arrives one cycle after tw_en
  cmul_round_sat u_cmul (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_c0_valid),
    .i_last  (r_c0_last),
    .i_a     (r_c0_re),
    .i_b     (r_c0_im),
    .i_c     (tw_cos),
    .i_s     (tw_sin),
    .o_valid (out_valid),
    .o_last  (out_last),
    .o_re    (out_re),
    .o_im    (out_im)
  );

endmodule

// File: tb/tb_fft_stage3_twiddle_mult.sv
// tb/tb_fft_stage3_twiddle_mult.sv - directed-vector bench with stage-3 twiddle ROM model
module tb_fft_stage3_twiddle_mult;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_sof;
  logic signed [15:0] in_re, in_im;
  logic               tw_en;
  logic [5:0]         tw_addr;
  logic signed [13:0] tw_cos, tw_sin;
  logic               out_valid;
  logic signed [15:0] out_re, out_im;
  logic               out_last;

  int n_vec  = 0;
  int n_miss = 0;

  fft_stage3_twiddle_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_en     (tw_en),
    .tw_addr   (tw_addr),
    .tw_cos    (tw_cos),
    .tw_sin    (tw_sin),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Stage-3 ROM: W = exp(-j*pi*a/4), Q2.12, sin column holds -sin
  always @(posedge clk) begin
    if (tw_en) begin
      case (tw_addr[2:0])
        3'd0: begin tw_cos <= 14'sd4096;  tw_sin <= 14'sd0;     end
        3'd1: begin tw_cos <= 14'sd2896;  tw_sin <= -14'sd2896; end
        3'd2: begin tw_cos <= 14'sd0;     tw_sin <= -14'sd4096; end
        3'd3: begin tw_cos <= -14'sd2896; tw_sin <= -14'sd2896; end
        3'd4: begin tw_cos <= -14'sd4096; tw_sin <= 14'sd0;     end
        3'd5: begin tw_cos <= -14'sd2896; tw_sin <= 14'sd2896;  end
        3'd6: begin tw_cos <= 14'sd0;     tw_sin <= 14'sd4096;  end
        default: begin tw_cos <= 14'sd2896; tw_sin <= 14'sd2896; end
      endcase
    end
  end

  bit mon_en = 1'b0;
  int mon_valid = 0;
  int mon_last = 0;
  int last_pos = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      mon_valid = mon_valid + 1;
      if (out_last) begin
        mon_last = mon_last + 1;
        last_pos = mon_valid;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic sof, input int re, input int im);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = 16'(re);
    in_im    = 16'(im);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
  endtask

  // Place (re,im) at sample index k of a fresh frame and check address and result
  task automatic one(input string tag, input int k, input int re, input int im,
                     input int exp_addr, input int exp_re, input int exp_im);
    if (k == 0) begin
      put(1'b1, re, im);
    end else begin
      put(1'b1, 0, 0);
      repeat (k - 1) put(1'b0, 0, 0);
      put(1'b0, re, im);
    end
    chk({tag, "_addr"}, tw_addr, exp_addr);
    idle(); idle(); idle();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_re"}, out_re, exp_re);
    chk({tag, "_im"}, out_im, exp_im);
    chk({tag, "_last"}, out_last, 0);
  endtask

  initial begin
    int addr_bad;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_tw_en", tw_en, 0);
    chk("rst_addr", tw_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    put(1'b1, 1000, -500);
    chk("unity_addr", tw_addr, 0);
    chk("unity_tw_en", tw_en, 1);
    idle(); idle();
    chk("unity_early", out_valid, 0);
    idle();
    chk("unity_valid", out_valid, 1);
    chk("unity_re", out_re, 1000);
    chk("unity_im", out_im, -500);
    chk("unity_last", out_last, 0);
    idle();
    chk("unity_bubble", out_valid, 0);
    chk("unity_hold_re", out_re, 1000);

    one("negj", 6, 1000, 0, 2, 0, -1000);
    one("rnd3", 5, 3, 0, 1, 2, -2);
    one("rnd4096", 5, 4096, 0, 1, 2896, -2896);
    one("satpos", 5, 32767, 32767, 1, 32767, 0);
    one("satneg", 5, -32768, -32768, 1, -32768, 0);
    one("idx3", 7, 4096, 0, 3, -2896, -2896);

    repeat (4) idle();
    mon_valid = 0; mon_last = 0; last_pos = 0; addr_bad = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      put(i == 0, i, -i);
      if (tw_addr !== 6'(((i % 8) >= 4) ? (i % 4) : 0)) addr_bad++;
    end
    repeat (4) idle();
    chk("frame_addr_errs", addr_bad, 0);
    chk("frame_valid_cnt", mon_valid, 256);
    chk("frame_last_cnt", mon_last, 1);
    chk("frame_last_pos", last_pos, 256);
    mon_valid = 0; mon_last = 0;
    for (int j = 0; j < 6; j++) put(1'b0, 0, 0);
    chk("wrap_addr_k5", tw_addr, 1);
    repeat (4) idle();
    chk("wrap_valid_cnt", mon_valid, 6);
    chk("wrap_no_last", mon_last, 0);
    mon_en = 1'b0;

    put(1'b1, 0, 0);
    repeat (3) put(1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_re", out_re, 0);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      idle();
      chk("midrst_quiet", out_valid, 0);
    end
    one("rst_sof", 0, 777, -3, 0, 777, -3);

    put(1'b1, 0, 0);
    repeat (99) put(1'b0, 0, 0);
    put(1'b1, 0, 0);
    chk("resync_addr_k0", tw_addr, 0);
    repeat (4) put(1'b0, 0, 0);
    put(1'b0, 4096, 0);
    chk("resync_addr_k5", tw_addr, 1);
    idle(); idle(); idle();
    chk("resync_re", out_re, 2896);
    chk("resync_im", out_im, -2896);
    repeat (2) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
